// File: rtl/anchor_scheduler.sv
// Raster-order window sequencer for the edge-detector pipeline: load, move, wait for stage finals.
// Optional busy-cycle counter on frame_cycles_o is built only when SCHED_PERF_EN is defined.
module anchor_scheduler #(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned STEP_X       = 14,
    parameter int unsigned NUM_STAGES   = 3,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start_i,
    input  logic                  load_done_i,
    input  logic [NUM_STAGES-1:0] stage_final_i,
    output logic                  load_req_o,
    output logic                  anchor_moving_o,
    output logic [31:0]           anchor_x_o,
    output logic [31:0]           anchor_y_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [31:0]           frame_cycles_o
);

    localparam logic [31:0] XMax  = 32'(IMG_WIDTH - 2);
    localparam logic [31:0] YMax  = 32'(IMG_HEIGHT - 2);
    localparam logic [31:0] Step  = 32'(STEP_X);
    localparam logic [31:0] Guard = 32'(GUARD_CYCLES);

    typedef enum logic [2:0] {StIdle, StLoad, StMove, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] ax_q, ax_d, ay_q, ay_d;
    logic [31:0] guard_q, guard_d;
    logic [31:0] nx, ny;
    logic        load_req_q, load_req_d;
    logic        moving_q, moving_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            ax_q       <= 32'd1;
            ay_q       <= 32'd1;
            guard_q    <= '0;
            load_req_q <= 1'b0;
            moving_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            guard_q    <= guard_d;
            load_req_q <= load_req_d;
            moving_q   <= moving_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        guard_d = guard_q;
        nx      = ax_q + Step;
        ny      = ay_q + 32'd1;
        case (state_q)
            StIdle: if (start_i) state_d = StLoad;
            StLoad: if (load_done_i) state_d = StMove;
            StMove: begin
                guard_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // Stages still report final from the previous window right after the move.
                if (guard_q < Guard) begin
                    guard_d = guard_q + 32'd1;
                end else if (&stage_final_i) begin
                    if (nx <= XMax) begin
                        ax_d    = nx;
                        state_d = StLoad;
                    end else if (ny <= YMax) begin
                        ax_d    = 32'd1;
                        ay_d    = ny;
                        state_d = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                ax_d    = 32'd1;
                ay_d    = 32'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        load_req_d = (state_d == StLoad);
        moving_d   = (state_d == StMove);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    assign load_req_o      = load_req_q;
    assign anchor_moving_o = moving_q;
    assign anchor_x_o      = ax_q;
    assign anchor_y_o      = ay_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = done_q;

`ifdef SCHED_PERF_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == StIdle) begin
            if (start_i) cyc_d = '0;
        end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign frame_cycles_o = cyc_q;
`else
    assign frame_cycles_o = '0;
`endif

endmodule
